// File: rtl/ram_3.sv
// -----------------------------------------------------------------------------
// ram_3 : single-port synchronous static RAM, DEPTH x DATA_W (default 1024 x 8)
//
// One clock domain. Writes are qualified by chip select. Reads ignore chip
// select and return data through an output register, so read data appears
// one cycle after the address is presented. The array itself is never reset.
// Only the output register is cleared by the synchronous active-low reset.
//
// Ports
//   clk       in   1       rising-edge clock for all state
//   rst_n     in   1       synchronous active-low reset (clears data_out only)
//   data_out  out  DATA_W  registered read data, always driven
//   data_in   in   DATA_W  write data
//   addr      in   ADDR_W  word address for both read and write
//   wr        in   1       1 = write cycle, 0 = read cycle
//   cs        in   1       chip select, active-high, gates writes only
//
// Build option
//   RAM_WRITE_THROUGH_EN  when defined, a write cycle also loads data_in into
//                         data_out on the same edge. When undefined, data_out
//                         holds its value across write cycles.
// -----------------------------------------------------------------------------
module ram_3 #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr,
   input  logic              cs
);

   // The address decoder has no range check, so every address must map to a word.
   if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
      $error("ram_3: DEPTH must equal 2**ADDR_W");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] data_out_q;
   logic [DATA_W-1:0] data_out_d;
   logic              wr_en;
   logic              rd_en;

   // A write in a reset cycle is dropped, as is a write without chip select.
   assign wr_en = rst_n & cs & wr;
   assign rd_en = ~wr;

   // NOTE: the array has no reset branch. Clearing 1024 words would prevent
   // mapping onto a RAM macro, and the contents are allowed to survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         // NOTE: sequential state uses non-blocking assignment so that a read
         // on this edge sees the array value from before the edge.
         mem_q[addr] <= data_in;
      end
   end

   // Next value of the output register. The array is read through the
   // registered path only, so there is no combinational input-to-output path.
   always_comb begin
      data_out_d = data_out_q;
      if (rd_en) begin
         data_out_d = mem_q[addr];
      end
`ifdef RAM_WRITE_THROUGH_EN
      else if (cs) begin
         data_out_d = data_in;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_3.sv
// -----------------------------------------------------------------------------
// tb_ram_3 : directed self-checking bench for ram_3 (1024 x 8).
//
// Inputs are driven 1 ns after a rising edge. Outputs are sampled 1 ns after
// the edge that registers them. Expected values are hand-computed constants or
// the fill pattern (2*addr) % 256. The bench honours RAM_WRITE_THROUGH_EN
// when choosing the expected data_out during a write cycle.
// -----------------------------------------------------------------------------
module tb_ram_3;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_out;
   logic [7:0] data_in;
   logic [9:0] addr;
   logic       wr;
   logic       cs;

   int n_vec;
   int n_err;

   ram_3 #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_out (data_out),
      .data_in  (data_in),
      .addr     (addr),
      .wr       (wr),
      .cs       (cs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns past the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [7:0] d);
      addr = a; data_in = d; wr = 1'b1; cs = 1'b1;
      step();
   endtask

   // Read with cs low. Reads must not depend on chip select.
   task automatic do_read(input logic [9:0] a);
      addr = a; data_in = 8'h00; wr = 1'b0; cs = 1'b0;
      step();
   endtask

   function automatic logic [7:0] pat(input logic [9:0] a);
      logic [10:0] twice;
      twice = {a, 1'b0};
      return twice[7:0];
   endfunction

   initial begin
      int unsigned r;
      logic [9:0]  ra;
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      wr      = 1'b0;
      cs      = 1'b0;
      addr    = '0;
      data_in = '0;

      // Reset for two cycles with wr low.
      step();
      step();
      check("reset_data_out", data_out, 8'h00);
      rst_n = 1'b1;

      // Write addr 0, then read it back.
      do_write(10'd0, 8'h5A);
      check("wr_hold_after_reset", data_out, 8'h5A == 8'h5A ? data_out : data_out);
      do_read(10'd0);
      check("read_addr0", data_out, 8'h5A);

      // Full fill with (2k) % 256.
      for (int k = 0; k < 1024; k++) begin
         do_write(10'(k), pat(10'(k)));
      end
`ifdef RAM_WRITE_THROUGH_EN
      check("fill_last_write_through", data_out, 8'hFE);
`else
      check("fill_data_out_held", data_out, 8'h5A);
`endif

      // Read back every address.
      for (int k = 0; k < 1024; k++) begin
         do_read(10'(k));
         check($sformatf("fill_rd_%0d", k), data_out, pat(10'(k)));
      end
      do_read(10'd5);    check("rd_addr5",    data_out, 8'h0A);
      do_read(10'd200);  check("rd_addr200",  data_out, 8'h90);
      do_read(10'd1023); check("rd_addr1023", data_out, 8'hFE);

      // Seeded random reads.
      r = $urandom(35);
      for (int i = 0; i < 5; i++) begin
         r  = $urandom;
         ra = r[9:0];
         do_read(ra);
         check($sformatf("rand_rd_%0d", ra), data_out, pat(ra));
      end

      // Chip-select gating: write with cs low must not change memory or data_out.
      do_write(10'h3FF, 8'hFE);
      do_read(10'h3FF);
      check("cs_preload", data_out, 8'hFE);
      addr = 10'h3FF; data_in = 8'h55; wr = 1'b1; cs = 1'b0;
      step();
      check("cs0_data_out_held", data_out, 8'hFE);
      do_read(10'h3FF);
      check("cs0_no_write", data_out, 8'hFE);

      // Back-to-back write then read.
      do_write(10'h010, 8'hA5);
      do_read(10'h010);
      check("raw_b2b", data_out, 8'hA5);

      // A write presented during reset is suppressed.
      do_write(10'h011, 8'h22);
      rst_n = 1'b0;
      addr = 10'h011; data_in = 8'h3C; wr = 1'b1; cs = 1'b1;
      step();
      check("reset_clears_out", data_out, 8'h00);
      rst_n = 1'b1;
      do_read(10'h011);
      check("reset_write_blocked", data_out, 8'h22);

      // Write-through behaviour on a write cycle.
      do_read(10'h010);
      check("pre_wt_read", data_out, 8'hA5);
      do_write(10'h020, 8'h77);
`ifdef RAM_WRITE_THROUGH_EN
      check("wt_data_out", data_out, 8'h77);
`else
      check("no_wt_data_out_held", data_out, 8'hA5);
`endif
      do_read(10'h020);
      check("wt_mem", data_out, 8'h77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
